// File: rtl/mem_responder_pkg.sv
// Shared types and address-decode helper for the mem_responder bus responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic [31:0] LED_OFS = 32'h0000_0000;
  localparam logic [31:0] CYC_OFS = 32'h0000_0004;

  typedef enum logic [1:0] {
    DEC_RAM = 2'd0,
    DEC_LED = 2'd1,
    DEC_CYC = 2'd2,
    DEC_ERR = 2'd3
  } dec_t;

  // Misalignment, unmapped space and writes to the read-only counter all fold into DEC_ERR.
  function automatic dec_t decode_addr(
    input logic [31:0] addr,
    input logic        we,
    input int          ram_aw,
    input logic [31:0] mmio_base
  );
    dec_t dec;
    if (addr[1:0] != 2'b00) begin
      dec = DEC_ERR;
    end else if ((addr >> (ram_aw + 2)) == 32'd0) begin
      dec = DEC_RAM;
    end else if (addr == (mmio_base + LED_OFS)) begin
      dec = DEC_LED;
    end else if (addr == (mmio_base + CYC_OFS)) begin
      dec = we ? DEC_ERR : DEC_CYC;
    end else begin
      dec = DEC_ERR;
    end
    return dec;
  endfunction

endpackage

// File: rtl/mem_responder_bram_be.sv
// Single-port word RAM with per-byte write enables and a registered 1-cycle read.
module bram_be #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Read returns the pre-write word on a simultaneous write; callers never rely on it.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory/MMIO responder: one outstanding request, serviced from block RAM or
// the LED/cycle-counter registers, answered on a valid/ready response channel.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] led
);

  state_t      r_state;
  state_t      w_state_next;
  dec_t        w_dec;
  logic        w_accept;
  logic        w_ram_en;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_rdata;
  logic [31:0] r_cycle;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [15:0] r_led;

  assign w_accept = req_valid && (r_state == IDLE);

  always_comb begin
    w_dec = decode_addr(req_addr, req_we, RAM_AW, MMIO_BASE);
  end

  // The RAM is only touched in the acceptance cycle, so request inputs need no capture register.
  assign w_ram_en = w_accept && (w_dec == DEC_RAM);
  assign w_ram_we = (w_ram_en && req_we) ? req_be : 4'b0000;

  bram_be #(
    .AW (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (req_addr[RAM_AW+1:2]),
    .i_wdata (req_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = ((w_dec == DEC_RAM) && !req_we) ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: w_state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      IDLE:    req_ready = 1'b1;
      RD_WAIT: req_ready = 1'b0;
      RESP:    rsp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Response payload is written on entry to RESP and held until the handshake clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rsp_err <= (w_dec == DEC_ERR);
            unique case (w_dec)
              DEC_LED: r_rsp_rdata <= req_we ? 32'h0 : {16'h0, r_led};
              DEC_CYC: r_rsp_rdata <= r_cycle;
              default: r_rsp_rdata <= 32'h0;
            endcase
          end
        end
        RD_WAIT: r_rsp_rdata <= w_ram_rdata;
        RESP: begin
          if (rsp_ready) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= 16'h0;
    end else if (w_accept && (w_dec == DEC_LED) && req_we) begin
      if (req_be[0]) begin
        r_led[7:0] <= req_wdata[7:0];
      end
      if (req_be[1]) begin
        r_led[15:8] <= req_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign led       = r_led;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Bus responder: the memory/MMIO end of the core's load/store path.
- Accepts one word-aligned request at a time from the core's memory initiator via a valid/ready request channel.
- Services the request from an internal synchronous word RAM or a small MMIO register file (LED register, free-running cycle counter).
- Returns read data or a write acknowledgement on a valid/ready response channel.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM spans byte addresses 0 .. 4*2**RAM_AW-1.
- MMIO_BASE, 32'h8000_0000, MMIO region base; LED at +0x0, CYCLE at +0x4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_be  in  4  byte enables for writes; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  misaligned, unmapped or illegal access
- led  out  16  LED register bits [15:0]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0; rsp_err 0; led 0; cycle counter 0. RAM contents are not reset.
- Handshake: a request transfers when req_valid && req_ready. A response transfers when rsp_valid && rsp_ready.
- Once rsp_valid is asserted, rsp_rdata and rsp_err stay stable until the response transfers.
- Request inputs are captured at acceptance. Their later values are ignored.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE: req_ready=1. On acceptance, classify the request:
  - Error: addr[1:0]!=0; or address neither in RAM nor MMIO; or a write to CYCLE. No side effect. Next state RESP with rsp_err=1, rsp_rdata=0.
  - RAM write: RAM written in the acceptance cycle with per-byte enables. Next state RESP, rsp_rdata=0.
  - RAM read: RAM read issued in the acceptance cycle. Next state RD_WAIT.
  - LED write: led[7:0] updated if be[0]; led[15:8] updated if be[1]; be[3:2] ignored. Next state RESP.
  - MMIO read: LED returns {16'b0, led}. CYCLE returns the counter value sampled in the acceptance cycle. Next state RESP.
- RD_WAIT: req_ready=0. RAM output is registered into rsp_rdata. Next state RESP.
- RESP: req_ready=0, rsp_valid=1. When rsp_ready=1, go to IDLE, drop rsp_valid and clear rsp_rdata/rsp_err to 0. A new request can be accepted the following cycle; there is no back-to-back overlap.
- Latency, with request accepted in cycle N and rsp_ready held high:
  - Write, MMIO read, error: rsp_valid in cycle N+1.
  - RAM read: rsp_valid in cycle N+2.
- Address decode:
  - RAM when addr[31:RAM_AW+2]==0.
  - MMIO when addr==MMIO_BASE or addr==MMIO_BASE+4.
  - Anything else is unmapped.
- Cycle counter: 32-bit, increments every cycle not in reset, wraps from FFFF_FFFF to 0.
- Reset mid-operation: immediate return to IDLE. Any pending response is discarded, with no rsp_valid. A RAM write already performed stays in place.
- Write with req_be=0: legal, no bytes change, normal acknowledgement.

Decomposition:
- Package mem_responder_pkg:
  - state enum (IDLE, RD_WAIT, RESP)
  - MMIO offset constants (LED_OFS=0, CYC_OFS=4)
  - decode-result enum (DEC_RAM, DEC_LED, DEC_CYC, DEC_ERR)
- Sub-module bram_be: single-port RAM with 2**RAM_AW 32-bit words, synchronous 1-cycle read, 4 byte-write enables, no read-during-write guarantee.

Test Plan:
- Write-read RAM: write 0xDEADBEEF to 0x10 with be=F, then read 0x10. Write response at N+1, err=0. Read rsp_rdata=0xDEADBEEF at N+2.
- Byte enables: write 0x11223344 to 0x20 with be=F, then 0xAABBCCDD with be=0101, then read 0x20 -> 0x11BB33DD.
- LED and backpressure: write 0x0001_A5A5 to MMIO_BASE with be=3 -> led=0xA5A5 next cycle. Read MMIO_BASE with rsp_ready low for 5 cycles -> rsp_valid stays 1, rsp_rdata stays 0x0000A5A5, req_ready stays 0.
- Errors:
  - Read 0x13 -> rsp_err=1, rsp_rdata=0.
  - Write 0x0001_0000 (unmapped) -> rsp_err=1, RAM unchanged.
  - Write to MMIO_BASE+4 -> rsp_err=1, counter unaffected.
- Cycle counter: read MMIO_BASE+4 twice with acceptances 10 cycles apart -> difference is 10.
- Reset mid-read: assert rst in RD_WAIT -> next cycle state IDLE, rsp_valid=0, led=0. A following read of 0x10 still returns the pre-reset data.
